// File: rtl/spi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_pkg : shared state type and length helpers for the SPI command sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } seq_state_t;

  // Widest transfer the mask helper supports; callers cast down to their width.
  localparam int MASK_W = 256;

  function automatic int spi_len_w(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_req_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_req_fifo : first-word fall-through request FIFO, async active-low reset
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_cmd_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_cmd_seq : queues host SPI requests and paces them into spi_drv
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_cmd_seq
  import spi_pkg::*;
#(
  parameter int SPI_MAXLEN = 32,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                              clk,
  input  logic                              sresetn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [spi_len_w(SPI_MAXLEN)-1:0]  req_len,
  input  logic [SPI_MAXLEN-1:0]             req_wdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [SPI_MAXLEN-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              busy,
  output logic                              start_cmd,
  input  logic                              spi_drv_rdy,
  output logic [spi_len_w(SPI_MAXLEN)-1:0]  n_clks,
  output logic [SPI_MAXLEN-1:0]             tx_data,
  input  logic [SPI_MAXLEN-1:0]             rx_miso
);

  localparam int LW = spi_len_w(SPI_MAXLEN);
  localparam int FW = LW + SPI_MAXLEN;
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES+1) : 1;

  seq_state_t            state_q,     state_d;
  logic                  start_q,     start_d;
  logic [LW-1:0]         nclk_q,      nclk_d;
  logic [SPI_MAXLEN-1:0] tx_q,        tx_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [SPI_MAXLEN-1:0] rdata_q,     rdata_d;
  logic                  err_q,       err_d;
  logic [TW-1:0]         to_cnt_q,    to_cnt_d;
  logic [GW-1:0]         gap_cnt_q,   gap_cnt_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [CW-1:0]         fifo_count;
  logic [FW-1:0]         fifo_head;
  logic [LW-1:0]         head_len;
  logic [SPI_MAXLEN-1:0] head_wdata;
  logic                  len_ok;
  logic [SPI_MAXLEN-1:0] rx_mask;

  assign req_ready  = ~fifo_full;
  assign head_len   = fifo_head[FW-1:SPI_MAXLEN];
  assign head_wdata = fifo_head[SPI_MAXLEN-1:0];
  assign len_ok     = (head_len != '0) && (head_len <= LW'(SPI_MAXLEN));
  assign rx_mask    = SPI_MAXLEN'(len_mask(int'(nclk_q)));

  spi_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (sresetn),
    .push_i  (req_valid & req_ready),
    .wdata_i ({req_len, req_wdata}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign start_cmd = start_q;
  assign n_clks    = nclk_q;
  assign tx_data   = tx_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      nclk_q      <= '0;
      tx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      nclk_q      <= nclk_d;
      tx_q        <= tx_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    nclk_d      = nclk_q;
    tx_d        = tx_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    to_cnt_d    = to_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && spi_drv_rdy) begin
          fifo_pop = 1'b1;
          if (len_ok) begin
            nclk_d   = head_len;
            tx_d     = head_wdata;
            start_d  = 1'b1;
            to_cnt_d = '0;
            state_d  = ISSUE;
          end else begin
            err_d       = 1'b1;
            rdata_d     = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (!spi_drv_rdy) begin
          start_d  = 1'b0;
          to_cnt_d = '0;
          state_d  = BUSY;
        end else if (to_cnt_d == TW'(TIMEOUT)) begin
          start_d     = 1'b0;
          err_d       = 1'b1;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          to_cnt_d    = '0;
          state_d     = RESP;
        end
      end
      BUSY: begin
        if (spi_drv_rdy) begin
          rdata_d     = rx_miso & rx_mask;
          err_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          gap_cnt_d   = '0;
          state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_d == GW'(GAP_CYCLES)) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_spi_cmd_seq : randomized bench with an spi_drv model and response model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_cmd_seq;

  localparam int MAXLEN = 32;
  localparam int DEPTH  = 4;
  localparam int GAP    = 3;
  localparam int TMO    = 10;
  localparam int LW     = 6;

  typedef struct {
    logic [LW-1:0] len;
    logic [31:0]   wdata;
    bit            stuck;
    int            mode;
  } beh_t;

  logic              clk = 1'b0;
  logic              sresetn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [LW-1:0]     req_len = '0;
  logic [MAXLEN-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [MAXLEN-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              start_cmd;
  logic              spi_drv_rdy;
  logic [LW-1:0]     n_clks;
  logic [MAXLEN-1:0] tx_data;
  logic [MAXLEN-1:0] rx_miso;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   drv_state = 0;
  bit   hold_rsp = 1'b0;
  beh_t beh_q[$];
  logic [32:0] exp_q[$];

  spi_cmd_seq #(
    .SPI_MAXLEN (MAXLEN),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .sresetn     (sresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .start_cmd   (start_cmd),
    .spi_drv_rdy (spi_drv_rdy),
    .n_clks      (n_clks),
    .tx_data     (tx_data),
    .rx_miso     (rx_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] miso_fn(input logic [31:0] tx, input int mode);
    case (mode)
      0:       return tx;
      1:       return 32'hFFFF_FFFF;
      default: return tx ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Expected response: bad length or stuck driver -> error with zero data,
  // otherwise the driver's MISO word trimmed to the low len bits.
  task automatic record(input logic [LW-1:0] len, input logic [31:0] wdata,
                        input bit stuck, input int mode);
    logic [63:0] m;
    int          l;
    l = int'(len);
    if (l >= 1 && l <= MAXLEN) begin
      beh_q.push_back('{len: len, wdata: wdata, stuck: stuck, mode: mode});
      m = (64'd1 << l) - 64'd1;
      if (stuck) exp_q.push_back({1'b1, 32'h0});
      else       exp_q.push_back({1'b0, miso_fn(wdata, mode) & m[31:0]});
    end else begin
      exp_q.push_back({1'b1, 32'h0});
    end
  endtask

  task automatic send(input logic [LW-1:0] len, input logic [31:0] wdata,
                      input bit stuck, input int mode);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_len   = len;
    req_wdata = wdata;
    while (!req_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      check_eq("req_accept_timeout", 0, 1);
    end else begin
      record(len, wdata, stuck, mode);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0 || drv_state != 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // Behavioural spi_drv: drops rdy a few cycles into start_cmd, stays busy a
  // while, then presents MISO and raises rdy. A stuck command never drops rdy.
  initial begin
    beh_t cur;
    int   cnt;
    int   hi;
    int   last_rise;
    cnt = 0; hi = 0; last_rise = -1000;
    cur = '{len: '0, wdata: '0, stuck: 1'b0, mode: 0};
    spi_drv_rdy = 1'b1;
    rx_miso     = '0;
    forever begin
      @(posedge clk); #1;
      if (!sresetn) begin
        drv_state   = 0;
        spi_drv_rdy = 1'b1;
        last_rise   = -1000;
        continue;
      end
      case (drv_state)
        0: if (start_cmd) begin
          if (last_rise >= 0) check_eq("start_spacing_ok", 64'((cyc - last_rise) >= GAP + 2), 1);
          last_rise = cyc;
          if (beh_q.size() == 0) begin
            check_eq("unexpected_start", 1, 0);
            cur = '{len: n_clks, wdata: tx_data, stuck: 1'b0, mode: 0};
          end else begin
            cur = beh_q.pop_front();
            check_eq("n_clks", n_clks, cur.len);
            check_eq("tx_data", tx_data, cur.wdata);
          end
          rx_miso = $urandom;
          hi = 1;
          if (cur.stuck) begin
            drv_state = 3;
          end else begin
            cnt = $urandom_range(0, 2);
            if (cnt == 0) begin
              spi_drv_rdy = 1'b0;
              drv_state   = 2;
            end else begin
              drv_state = 1;
            end
          end
        end
        1: begin
          check_eq("cmd_stable", {start_cmd, n_clks, tx_data}, {1'b1, cur.len, cur.wdata});
          cnt--;
          if (cnt == 0) begin
            spi_drv_rdy = 1'b0;
            drv_state   = 2;
          end
        end
        2: begin
          if (start_cmd) begin
            check_eq("cmd_stable", {start_cmd, n_clks, tx_data}, {1'b1, cur.len, cur.wdata});
          end else begin
            cnt       = $urandom_range(1, 4);
            drv_state = 4;
          end
        end
        3: begin
          if (start_cmd && hi <= TMO + 4) begin
            hi++;
            check_eq("cmd_stable", {start_cmd, n_clks, tx_data}, {1'b1, cur.len, cur.wdata});
          end else begin
            check_eq("timeout_start_cycles", hi, TMO);
            drv_state = 0;
          end
        end
        default: begin
          cnt--;
          if (cnt == 0) begin
            rx_miso     = miso_fn(cur.wdata, cur.mode);
            spi_drv_rdy = 1'b1;
            drv_state   = 0;
          end
        end
      endcase
    end
  end

  // Response sink: random back-pressure, compares each accepted response.
  initial begin
    logic [32:0] e;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (sresetn && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_err_rdata", {rsp_err, rsp_rdata}, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [LW-1:0] len;
    bit ok;

    #3;
    check_eq("reset_outputs", {start_cmd, rsp_valid, rsp_err, busy, req_ready},
             {1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (3) @(posedge clk);
    #3 sresetn = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_data", {n_clks, tx_data, rsp_rdata}, '0);

    send(6'd8, 32'h0000_00A5, 1'b0, 0);
    check_eq("latency_k_start", start_cmd, 0);
    check_eq("latency_k_busy", busy, 1);
    @(posedge clk); #1;
    check_eq("latency_k1_start", start_cmd, 1);
    wait_idle("single_done");

    send(6'd32, 32'hDEAD_BEEF, 1'b0, 1);
    send(6'd5, 32'h1234_5678, 1'b0, 1);
    wait_idle("mask_done");

    send(6'd0, 32'hFFFF_FFFF, 1'b0, 0);
    send(6'd33, 32'h0F0F_0F0F, 1'b0, 0);
    wait_idle("badlen_done");

    send(6'd16, 32'hCAFE_F00D, 1'b1, 0);
    send(6'd12, 32'h0000_0ABC, 1'b0, 2);
    wait_idle("timeout_done");

    hold_rsp = 1'b1;
    for (int i = 0; i < 5; i++) send(6'(i + 3), $urandom, 1'b0, 0);
    check_eq("req_ready_full", req_ready, 0);
    check_eq("busy_full", busy, 1);
    hold_rsp = 1'b0;
    wait_idle("full_done");

    for (int i = 0; i < 40; i++) begin
      ok = ($urandom_range(0, 4) != 0);
      if (ok) len = 6'($urandom_range(1, MAXLEN));
      else    len = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
      send(len, $urandom, ok && ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle("random_done");

    send(6'd20, $urandom, 1'b0, 2);
    t = 0;
    do begin
      @(posedge clk); #2;
      t++;
    end while (drv_state != 4 && t < 200);
    check_eq("reached_busy", drv_state, 4);
    sresetn = 1'b0;
    #1;
    check_eq("reset_mid_ctrl", {start_cmd, rsp_valid, busy, req_ready},
             {1'b0, 1'b0, 1'b0, 1'b1});
    check_eq("reset_mid_data", {n_clks, tx_data}, '0);
    exp_q.delete();
    beh_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 sresetn = 1'b1;
    @(posedge clk); #1;
    send(6'd12, 32'h0000_0777, 1'b0, 0);
    wait_idle("after_reset_done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_cmd_seq.md
# spi_cmd_seq

Command sequencer that sits directly upstream of `spi_drv`. It accepts SPI transfer requests from the host over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to `spi_drv` using the `start_cmd`/`spi_drv_rdy` handshake, then returns each received word with an error flag over a valid/ready response interface. It frees the host from pacing `spi_drv` and holding `tx_data` stable.

## Interface
- `SPI_MAXLEN`, 32: maximum transfer length in bits; must match `spi_drv`.
- `DEPTH`, 4: request FIFO depth; power of 2, ≥2.
- `GAP_CYCLES`, 8: idle clk cycles enforced between response acceptance and the next `start_cmd`; 0 allowed.
- `TIMEOUT`, 255: clk cycles allowed for `spi_drv_rdy` to fall after `start_cmd` rises; must be ≥1.
- `clk` in 1: single clock. The block has one clock.
- `sresetn` in 1: reset, asynchronous assert, active-low. All flops are cleared immediately when it is low.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: equals `!fifo_full`.
- `req_len` in LW=$clog2(SPI_MAXLEN)+1: number of bits to transfer.
- `req_wdata` in SPI_MAXLEN: MOSI data, right-justified.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: host accepts the response.
- `rsp_rdata` out SPI_MAXLEN: received MISO data, right-justified and masked to `len` bits.
- `rsp_err` out 1: the request was rejected or timed out.
- `busy` out 1: state≠IDLE or FIFO not empty.
- `start_cmd` out 1: to `spi_drv`; registered.
- `spi_drv_rdy` in 1: from `spi_drv`.
- `n_clks` out LW: to `spi_drv`; registered and held stable while `start_cmd`=1.
- `tx_data` out SPI_MAXLEN: to `spi_drv`; registered and held stable while `start_cmd`=1.
- `rx_miso` in SPI_MAXLEN: from `spi_drv`.

## Operation
- Reset values are 0 for all of the following: `start_cmd`, `n_clks`, `tx_data`, `rsp_valid`, `rsp_rdata`, `rsp_err`, FIFO pointers/count, gap and timeout counters. State resets to IDLE. `req_ready` is 1 out of reset and `busy` is 0.
- FIFO:
  - A push occurs on `req_valid & req_ready` and stores {len, wdata}.
  - A pop occurs only on the IDLE exit.
  - A push and pop in the same cycle leaves the count unchanged.
  - While the FIFO is full, `req_ready`=0, even if a pop happens in that cycle.
- IDLE: when the FIFO is non-empty and `spi_drv_rdy`=1, pop the head and latch `len`.
  - If `len` is in 1..SPI_MAXLEN: set `n_clks`←len, `tx_data`←wdata, `start_cmd`←1, and go to ISSUE.
  - Otherwise (`len`=0 or `len`>SPI_MAXLEN): set `rsp_err`←1, `rsp_rdata`←0, and go to RESP. No SPI activity occurs.
- ISSUE: hold `start_cmd`=1; the timeout counter increments each cycle.
  - When `spi_drv_rdy` is sampled 0: `start_cmd`←0, go to BUSY.
  - Otherwise, when the counter reaches TIMEOUT: `start_cmd`←0, `rsp_err`←1, `rsp_rdata`←0, go to RESP.
- BUSY: wait for `spi_drv_rdy` to be sampled 1. Then `rsp_rdata`←`rx_miso` & mask(len) and `rsp_err`←0, and go to RESP.
  - mask(len) has the low `len` bits set; it is all ones when `len`=SPI_MAXLEN.
  - BUSY has no timeout.
- RESP: `rsp_valid`=1, and `rsp_rdata`/`rsp_err` are stable. On `rsp_ready`, go to GAP, or directly to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests may still be pushed during GAP.

## Timing
- Request to command latency:
  - Request accepted at edge k, FIFO empty, state IDLE, `spi_drv_rdy`=1: FIFO is non-empty after edge k, and `start_cmd`=1 after edge k+1.
- `start_cmd` falls on the edge after `spi_drv_rdy` is first sampled 0. The driver latches its inputs in its load cycle, which is covered by this hold.
- `rsp_valid` rises on the edge after `spi_drv_rdy` is sampled 1 in BUSY.
- `rsp_valid` drops on the edge where `rsp_valid & rsp_ready`.
- Back-to-back transfers are separated by:
  - 1 cycle for the `rsp_valid` drop,
  - plus GAP_CYCLES,
  - plus 1 cycle in IDLE.
- Reset asserted mid-transfer: `start_cmd` goes to 0 and FIFO contents are lost immediately. No response is produced for the in-flight request.

## Structure
- Shared package `spi_pkg`:
  - `seq_state_t` enum {IDLE, ISSUE, BUSY, RESP, GAP},
  - `spi_len_w` function ($clog2(maxlen)+1),
  - `len_mask` function.
- Sub-module `spi_req_fifo`: parameters DEPTH and WIDTH=LW+SPI_MAXLEN. It is first-word fall-through, with push/pop/full/empty/count and asynchronous active-low reset.
- The top level contains the FSM, the output registers and the two counters (gap and timeout, each $clog2(max+1) bits).

## Test plan
- Single request, `len`=8, `wdata`=0xA5, driver model echoes MOSI to MISO → `n_clks`=8 and `tx_data`=0xA5 stable while `start_cmd`=1; response `rdata`=0xA5, `err`=0; `start_cmd`=1 exactly 2 edges after acceptance.
- `len`=32, `wdata`=0xDEADBEEF, MISO tied 1 → `rdata`=0xFFFFFFFF; `len`=5 with MISO tied 1 → `rdata`=0x1F.
- `len`=0, then `len`=33 → two responses with `err`=1, `rdata`=0; `start_cmd` never asserts.
- Driver model never drops `spi_drv_rdy`, TIMEOUT=10 → `start_cmd` high for 10 cycles, then response `err`=1; the next queued request proceeds normally.
- Push 5 requests back-to-back with DEPTH=4, `rsp_ready` held 0 → `req_ready`=0 after 4 pushes with one transfer in flight. Releasing `rsp_ready` returns responses in order, with ≥GAP_CYCLES+2 cycles between `start_cmd` rises.
- Assert reset while in BUSY → all outputs go to 0 immediately, `busy`=0. After release, a new request completes normally.
